// File: rtl/deser400_rate_monitor_if.sv
// rtl/deser400_rate_monitor_if.sv - gate/event inputs and select/ack readout bus of the deser400 rate monitor
interface deser400_rate_monitor_if #(
  parameter int NEV = 4,
  parameter int CW  = 16,
  parameter int SW  = 2
);
  logic           gate;
  logic [NEV-1:0] ev;
  logic [SW-1:0]  sel;
  logic [CW-1:0]  data;
  logic           valid;
  logic           ack;
  logic           busy;
  logic           overrun;
  logic [NEV-1:0] sat;

  // master: gate generator, decoders and software reader; slave: the monitor
  modport master (output gate, ev, sel, ack, input data, valid, busy, overrun, sat);
  modport slave  (input gate, ev, sel, ack, output data, valid, busy, overrun, sat);
endinterface

// File: rtl/deser400_rate_monitor.sv
// rtl/deser400_rate_monitor.sv - per-source event counters over a gate window, shadowed for select/ack readout
// Optional saturating counters with per-counter flags: define DESER400_RATE_SAT_EN.
module deser400_rate_monitor #(
  parameter int NEV = 4,
  parameter int CW  = 16,
  parameter int SW  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  deser400_rate_monitor_if.slave   bus
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state;
  logic          gate_q;
  logic          busy_q;
  logic          valid_q;
  logic          overrun_q;
  logic [CW-1:0] data_q;
  logic [CW-1:0] cnt    [NEV];
  logic [CW-1:0] shadow [NEV];

  logic rise;
  logic win_end;

  // gate_q resets high so a window already open at reset release never counts
  assign rise    = bus.gate & ~gate_q;
  assign win_end = (state == COUNT) & ~bus.gate & gate_q;

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.data    = data_q;

`ifdef DESER400_RATE_SAT_EN
  localparam logic [CW-1:0] CMAX = '1;
  logic [NEV-1:0] sat_int;
  logic [NEV-1:0] sat_q;
  assign bus.sat = sat_q;
`else
  assign bus.sat = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gate_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      for (int i = 0; i < NEV; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
`ifdef DESER400_RATE_SAT_EN
      sat_int <= '0;
      sat_q   <= '0;
`endif
    end else begin
      gate_q <= bus.gate;

      case (state)
        IDLE: begin
          if (rise) begin
            state  <= COUNT;
            busy_q <= 1'b1;
            // loading ev directly discards the previous window's count
            for (int i = 0; i < NEV; i++)
              cnt[i] <= CW'(bus.ev[i]);
`ifdef DESER400_RATE_SAT_EN
            sat_int <= '0;
`endif
          end
        end
        COUNT: begin
          if (win_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            for (int i = 0; i < NEV; i++)
              shadow[i] <= cnt[i];
`ifdef DESER400_RATE_SAT_EN
            sat_q <= sat_int;
`endif
          end else begin
            for (int i = 0; i < NEV; i++) begin
`ifdef DESER400_RATE_SAT_EN
              if (bus.ev[i] && (cnt[i] != CMAX))
                cnt[i] <= cnt[i] + CW'(1);
              if (bus.ev[i] && (cnt[i] == CMAX - CW'(1)))
                sat_int[i] <= 1'b1;
`else
              cnt[i] <= cnt[i] + CW'(bus.ev[i]);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase

      // a completed window while a result is pending is an overrun unless acked in the same cycle
      if (win_end) begin
        valid_q <= 1'b1;
        if (valid_q && bus.ack)
          overrun_q <= 1'b0;
        else if (valid_q)
          overrun_q <= 1'b1;
      end else if (valid_q && bus.ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      data_q <= (int'(bus.sel) < NEV) ? shadow[bus.sel] : '0;
    end
  end

endmodule

// File: tb/tb_deser400_rate_monitor.sv
// tb/tb_deser400_rate_monitor.sv - directed self-checking bench for deser400_rate_monitor
module tb_deser400_rate_monitor;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  deser400_rate_monitor_if #(.NEV(4), .CW(16), .SW(2)) bus_a ();
  deser400_rate_monitor_if #(.NEV(4), .CW(4),  .SW(2)) bus_b ();

  deser400_rate_monitor #(.NEV(4), .CW(16), .SW(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  deser400_rate_monitor #(.NEV(4), .CW(4), .SW(2)) u_dut_cw4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate high for len cycles; ma pulses every cycle, mb on even cycles; ev=F in the fall cycle must not count
  task automatic window(input int len, input logic [3:0] ma, input logic [3:0] mb, input logic ack_fall);
    bus_a.gate = 1'b1;
    for (int k = 0; k < len; k++) begin
      bus_a.ev = ma | (((k % 2) == 0) ? mb : 4'b0000);
      @(negedge clk);
    end
    bus_a.gate = 1'b0;
    bus_a.ev   = 4'hF;
    bus_a.ack  = ack_fall;
    @(negedge clk);
    bus_a.ev   = 4'h0;
    bus_a.ack  = 1'b0;
  endtask

  task automatic do_ack();
    bus_a.ack = 1'b1;
    @(negedge clk);
    bus_a.ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.gate = 1'b0; bus_a.ev = '0; bus_a.sel = '0; bus_a.ack = 1'b0;
    bus_b.gate = 1'b0; bus_b.ev = '0; bus_b.sel = '0; bus_b.ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.valid, bus_a.busy, bus_a.overrun} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {bus_a.valid, bus_a.busy, bus_a.overrun});
    end
    checks++;
    if (bus_a.data !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got=%0d exp=0", bus_a.data);
    end
    checks++;
    if (bus_a.sat !== 4'b0000) begin
      failures++;
      $display("FAIL reset_sat got=%b exp=0000", bus_a.sat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_count();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'd10; exp_d[1] = 16'd5; exp_d[2] = 16'd0; exp_d[3] = 16'd0;
    window(10, 4'b0001, 4'b0010, 1'b0);
    checks++;
    if (bus_a.valid !== 1'b1) begin
      failures++;
      $display("FAIL t1_valid got=%b exp=1", bus_a.valid);
    end
    checks++;
    if ({bus_a.busy, bus_a.overrun} !== 2'b00) begin
      failures++;
      $display("FAIL t1_busy_overrun got=%b exp=00", {bus_a.busy, bus_a.overrun});
    end
    for (int s = 0; s < 4; s++) begin
      bus_a.sel = 2'(s);
      @(negedge clk);
      checks++;
      if (bus_a.data !== exp_d[s]) begin
        failures++;
        $display("FAIL t1_data_sel%0d got=%0d exp=%0d", s, bus_a.data, exp_d[s]);
      end
    end
    do_ack();
    checks++;
    if (bus_a.valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_ack_valid got=%b exp=0", bus_a.valid);
    end
  endtask

  task automatic test_open_window_at_reset();
    reset = 1'b1;
    bus_a.gate = 1'b1;
    bus_a.ev   = 4'hF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b0) begin
      failures++;
      $display("FAIL t2_busy_open got=%b exp=0", bus_a.busy);
    end
    bus_a.gate = 1'b0;
    bus_a.ev   = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_a.valid !== 1'b0) begin
      failures++;
      $display("FAIL t2_no_valid got=%b exp=0", bus_a.valid);
    end
    window(3, 4'b1000, 4'b0000, 1'b0);
    checks++;
    if (bus_a.valid !== 1'b1) begin
      failures++;
      $display("FAIL t2_valid got=%b exp=1", bus_a.valid);
    end
    bus_a.sel = 2'd3;
    @(negedge clk);
    checks++;
    if (bus_a.data !== 16'd3) begin
      failures++;
      $display("FAIL t2_data got=%0d exp=3", bus_a.data);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    window(4, 4'b0001, 4'b0000, 1'b0);
    checks++;
    if ({bus_a.valid, bus_a.overrun} !== 2'b10) begin
      failures++;
      $display("FAIL t3_first got=%b exp=10", {bus_a.valid, bus_a.overrun});
    end
    window(6, 4'b0000, 4'b0100, 1'b0);
    checks++;
    if ({bus_a.valid, bus_a.overrun} !== 2'b11) begin
      failures++;
      $display("FAIL t3_overrun got=%b exp=11", {bus_a.valid, bus_a.overrun});
    end
    bus_a.sel = 2'd2;
    @(negedge clk);
    checks++;
    if (bus_a.data !== 16'd3) begin
      failures++;
      $display("FAIL t3_data_sel2 got=%0d exp=3", bus_a.data);
    end
    bus_a.sel = 2'd0;
    @(negedge clk);
    checks++;
    if (bus_a.data !== 16'd0) begin
      failures++;
      $display("FAIL t3_data_sel0 got=%0d exp=0", bus_a.data);
    end
    do_ack();
    checks++;
    if ({bus_a.valid, bus_a.overrun} !== 2'b00) begin
      failures++;
      $display("FAIL t3_ack got=%b exp=00", {bus_a.valid, bus_a.overrun});
    end
  endtask

  task automatic test_ack_in_fall();
    window(5, 4'b0001, 4'b0000, 1'b0);
    window(2, 4'b0001, 4'b0000, 1'b0);
    checks++;
    if (bus_a.overrun !== 1'b1) begin
      failures++;
      $display("FAIL t4_pre_overrun got=%b exp=1", bus_a.overrun);
    end
    window(7, 4'b0010, 4'b0000, 1'b1);
    checks++;
    if ({bus_a.valid, bus_a.overrun} !== 2'b10) begin
      failures++;
      $display("FAIL t4_flags got=%b exp=10", {bus_a.valid, bus_a.overrun});
    end
    bus_a.sel = 2'd1;
    @(negedge clk);
    checks++;
    if (bus_a.data !== 16'd7) begin
      failures++;
      $display("FAIL t4_data_sel1 got=%0d exp=7", bus_a.data);
    end
    bus_a.sel = 2'd0;
    @(negedge clk);
    checks++;
    if (bus_a.data !== 16'd0) begin
      failures++;
      $display("FAIL t4_data_sel0 got=%0d exp=0", bus_a.data);
    end
    do_ack();
  endtask

  task automatic test_saturation();
    logic [3:0] exp_d;
    logic [3:0] exp_sat;
`ifdef DESER400_RATE_SAT_EN
    exp_d = 4'd15; exp_sat = 4'b0001;
`else
    exp_d = 4'd4;  exp_sat = 4'b0000;
`endif
    bus_b.gate = 1'b1;
    bus_b.ev   = 4'b0001;
    repeat (20) @(negedge clk);
    bus_b.gate = 1'b0;
    bus_b.ev   = 4'b0000;
    @(negedge clk);
    bus_b.sel = 2'd0;
    @(negedge clk);
    checks++;
    if (bus_b.data !== exp_d) begin
      failures++;
      $display("FAIL t5_data got=%0d exp=%0d", bus_b.data, exp_d);
    end
    checks++;
    if (bus_b.sat !== exp_sat) begin
      failures++;
      $display("FAIL t5_sat got=%b exp=%b", bus_b.sat, exp_sat);
    end
    checks++;
    if (bus_a.sat !== 4'b0000) begin
      failures++;
      $display("FAIL t5_sat_cw16 got=%b exp=0000", bus_a.sat);
    end
  endtask

  task automatic test_reset_mid_window();
    window(2, 4'b0001, 4'b0000, 1'b0);
    window(1, 4'b0001, 4'b0000, 1'b0);
    bus_a.sel = 2'd0;
    @(negedge clk);
    bus_a.gate = 1'b1;
    bus_a.ev   = 4'b1000;
    repeat (5) @(negedge clk);
    checks++;
    if (bus_a.busy !== 1'b1) begin
      failures++;
      $display("FAIL t6_busy_mid got=%b exp=1", bus_a.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.valid, bus_a.busy, bus_a.overrun} !== 3'b000) begin
      failures++;
      $display("FAIL t6_reset_flags got=%b exp=000", {bus_a.valid, bus_a.busy, bus_a.overrun});
    end
    checks++;
    if (bus_a.data !== 16'd0) begin
      failures++;
      $display("FAIL t6_reset_data got=%0d exp=0", bus_a.data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    bus_a.gate = 1'b0;
    bus_a.ev   = 4'b0000;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.valid !== 1'b0) begin
      failures++;
      $display("FAIL t6_no_valid got=%b exp=0", bus_a.valid);
    end
    window(4, 4'b1000, 4'b0000, 1'b0);
    bus_a.sel = 2'd3;
    @(negedge clk);
    checks++;
    if ({bus_a.valid, bus_a.data} !== {1'b1, 16'd4}) begin
      failures++;
      $display("FAIL t6_next_window got=valid %b data %0d exp=valid 1 data 4", bus_a.valid, bus_a.data);
    end
    do_ack();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_count();
    test_open_window_at_reset();
    test_overrun();
    test_ack_in_fall();
    test_saturation();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
